// File: rtl/axis_endpoint_arbiter_if.sv
// Bundle of LANES parallel AXI-Stream channels. The arbiter takes a multi-lane
// instance for its requesters and a single-lane instance toward the mesh.
interface axis_endpoint_arbiter_if #(
  parameter int LANES       = 1,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 32,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4
);
  // A beat transfers on a rising clk edge where tvalid and tready are both high.
  // tvalid, once raised, stays high with a stable payload until that transfer.
  logic [LANES-1:0]                  tvalid;
  logic [LANES-1:0]                  tready;
  logic [LANES-1:0]                  tlast;
  logic [LANES-1:0][TDATA_WIDTH-1:0] tdata;
  logic [LANES-1:0][TUSER_WIDTH-1:0] tuser;
  logic [LANES-1:0][TID_WIDTH-1:0]   tid;
  logic [LANES-1:0][TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tlast, tdata, tuser, tid, tdest, input tready);
  modport slave  (input tvalid, tlast, tdata, tuser, tid, tdest, output tready);
endinterface

// File: rtl/axis_endpoint_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream mesh input among
// NUM_REQ requesters, with a single registered output stage.
module axis_endpoint_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TID_WIDTH    = 2,
  parameter int TDEST_WIDTH  = 4,
  parameter int TDATA_WIDTH  = 512,
  parameter int TUSER_WIDTH  = 32,
  parameter int HOLD_PACKETS = 1,
  parameter int TAG_TID      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_endpoint_arbiter_if.slave     s,
  axis_endpoint_arbiter_if.master    m,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       state_dbg
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   mid_q, mid_d;
  logic                   mv_q, mv_d;
  logic                   ml_q, ml_d;
  logic [TDATA_WIDTH-1:0] md_q, md_d;
  logic [TUSER_WIDTH-1:0] mu_q, mu_d;
  logic [TID_WIDTH-1:0]   mi_q, mi_d;
  logic [TDEST_WIDTH-1:0] mt_q, mt_d;

  logic [IW-1:0]          pick;
  logic                   found;
  int                     j;
  logic [NUM_REQ-1:0]     gmask;
  logic                   out_free;
  logic                   acc;
  logic                   others_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      mid_q   <= 1'b0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
      md_q    <= '0;
      mu_q    <= '0;
      mi_q    <= '0;
      mt_q    <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      mid_q   <= mid_d;
      mv_q    <= mv_d;
      ml_q    <= ml_d;
      md_q    <= md_d;
      mu_q    <= mu_d;
      mi_q    <= mi_d;
      mt_q    <= mt_d;
    end
  end

  // Circular search for the first valid requester after the last owner.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(last_q) + i) % NUM_REQ;
      if (!found && s.tvalid[j]) begin
        pick  = IW'(j);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    mid_d   = mid_q;
    mv_d    = mv_q & ~m.tready[0];
    ml_d    = ml_q;
    md_d    = md_q;
    mu_d    = mu_q;
    mi_d    = mi_q;
    mt_d    = mt_q;
    case (state_q)
      IDLE: begin
        if (|s.tvalid) begin
          state_d = BUSY;
          gidx_d  = pick;
          cnt_d   = '0;
          mid_d   = 1'b0;
        end
      end
      BUSY: begin
        if (acc) begin
          if (s.tlast[gidx_q]) begin
            mid_d = 1'b0;
            if ((cnt_q + 8'd1) == 8'(HOLD_PACKETS)) begin
              state_d = IDLE;
              last_d  = gidx_q;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            mid_d = 1'b1;
          end
        // Yield only between packets, never inside one.
        end else if (cnt_q != 8'd0 && !mid_q && !s.tvalid[gidx_q] && others_valid) begin
          state_d = IDLE;
          last_d  = gidx_q;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (acc) begin
      mv_d = 1'b1;
      ml_d = s.tlast[gidx_q];
      md_d = s.tdata[gidx_q];
      mu_d = s.tuser[gidx_q];
      mi_d = (TAG_TID != 0) ? TID_WIDTH'(gidx_q) : s.tid[gidx_q];
      mt_d = s.tdest[gidx_q];
    end
  end

  always_comb begin
    out_free         = ~mv_q | m.tready[0];
    gmask            = '0;
    gmask[gidx_q]    = 1'b1;
    others_valid     = |(s.tvalid & ~gmask);
    s.tready         = (state_q == BUSY && out_free) ? gmask : '0;
    acc              = (state_q == BUSY) && s.tvalid[gidx_q] && out_free;
    grant_valid      = (state_q == BUSY);
    grant_idx        = gidx_q;
    state_dbg        = state_q;
    m.tvalid[0]      = mv_q;
    m.tlast[0]       = ml_q;
    m.tdata[0]       = md_q;
    m.tuser[0]       = mu_q;
    m.tid[0]         = mi_q;
    m.tdest[0]       = mt_q;
  end
endmodule
